user_ddr_arbiter: RTL and testbench

- Downstream neighbour of the user DDR stream generator.
- Accepts its read-request and two-beat write-request handshakes and arbitrates between them.
- Drives a MIG-style DDR application interface: command, write-data FIFO and read-return path.
- Single clock domain (i_ddr_clk); 512-bit bursts split as two 256-bit beats.

---
 rtl/user_ddr_arbiter.sv | 138 +++++++++++++
 tb/tb_user_ddr_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : user_ddr_arbiter
// Purpose  : Round-robin read/write arbiter onto a MIG-style DDR app interface.
// Revision : 1.0 - initial release
// ============================================================================
module user_ddr_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_RD_OUT = 64
) (
    input  logic              i_ddr_clk,
    input  logic              i_rst_n,
    input  logic              i_ddr_rd_req,
    output logic              o_ddr_rd_ack,
    input  logic [ADDR_W-1:0] i_ddr_rd_addr,
    output logic              o_ddr_rd_data_valid,
    output logic [255:0]      o_ddr_rd_data,
    input  logic              i_ddr_wr_req,
    output logic              o_ddr_wr_ack,
    input  logic [ADDR_W-1:0] i_ddr_wr_addr,
    input  logic [255:0]      i_ddr_wr_data,
    input  logic [31:0]       i_ddr_wr_be_n,
    output logic              o_app_en,
    output logic [2:0]        o_app_cmd,
    output logic [ADDR_W-1:0] o_app_addr,
    input  logic              i_app_rdy,
    output logic              o_app_wdf_wren,
    output logic              o_app_wdf_end,
    output logic [255:0]      o_app_wdf_data,
    output logic [31:0]       o_app_wdf_mask,
    input  logic              i_app_wdf_rdy,
    input  logic [255:0]      i_app_rd_data,
    input  logic              i_app_rd_data_valid,
    input  logic              i_app_rd_data_end
);

    localparam logic [7:0] c_max_rd_out = 8'(MAX_RD_OUT);
    localparam logic [2:0] c_cmd_wr     = 3'b000;
    localparam logic [2:0] c_cmd_rd     = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CMD   = 3'd1,
        S_WR_BEAT0 = 3'd2,
        S_WR_BEAT1 = 3'd3,
        S_WR_CMD   = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_last_grant_wr;
    logic [7:0]        r_rd_out;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic              r_rd_data_valid;
    logic [255:0]      r_rd_data;

    logic w_rd_ok;
    logic w_both;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_app_en;
    logic w_wdf_active;
    logic w_rd_accept;
    logic w_rd_done;

    // On a tie the side that did not win last time is granted.
    assign w_rd_ok    = i_ddr_rd_req && (r_rd_out < c_max_rd_out);
    assign w_both     = w_rd_ok && i_ddr_wr_req;
    assign w_grant_rd = (r_state == S_IDLE) && (w_both ? r_last_grant_wr : w_rd_ok);
    assign w_grant_wr = (r_state == S_IDLE) && (w_both ? !r_last_grant_wr : i_ddr_wr_req);

    assign w_app_en     = (r_state == S_RD_CMD) || (r_state == S_WR_CMD);
    assign w_wdf_active = (r_state == S_WR_BEAT0) || (r_state == S_WR_BEAT1);
    assign w_rd_accept  = (r_state == S_RD_CMD) && i_app_rdy;
    assign w_rd_done    = i_app_rd_data_valid && i_app_rd_data_end && (r_rd_out != 8'd0);

    always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_last_grant_wr <= 1'b1;
            r_cmd_addr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_rd) begin
                        r_state         <= S_RD_CMD;
                        r_cmd_addr      <= i_ddr_rd_addr;
                        r_last_grant_wr <= 1'b0;
                    end else if (w_grant_wr) begin
                        r_state         <= S_WR_BEAT0;
                        r_cmd_addr      <= i_ddr_wr_addr;
                        r_last_grant_wr <= 1'b1;
                    end
                end
                S_RD_CMD:   if (i_app_rdy)     r_state <= S_IDLE;
                S_WR_BEAT0: if (i_app_wdf_rdy) r_state <= S_WR_BEAT1;
                S_WR_BEAT1: if (i_app_wdf_rdy) r_state <= S_WR_CMD;
                S_WR_CMD:   if (i_app_rdy)     r_state <= S_IDLE;
                default:                       r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_out <= 8'd0;
        end else begin
            case ({w_rd_accept, w_rd_done})
                2'b10:   r_rd_out <= r_rd_out + 8'd1;
                2'b01:   r_rd_out <= r_rd_out - 8'd1;
                default: r_rd_out <= r_rd_out;
            endcase
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_rd_data_valid <= i_app_rd_data_valid;
            r_rd_data       <= i_app_rd_data;
        end
    end

    assign o_ddr_rd_ack        = w_rd_accept;
    assign o_ddr_wr_ack        = w_wdf_active && i_app_wdf_rdy;
    assign o_ddr_rd_data_valid = r_rd_data_valid;
    assign o_ddr_rd_data       = r_rd_data;
    assign o_app_en            = w_app_en;
    assign o_app_cmd           = (r_state == S_RD_CMD) ? c_cmd_rd : c_cmd_wr;
    assign o_app_addr          = w_app_en ? r_cmd_addr : '0;
    assign o_app_wdf_wren      = w_wdf_active;
    assign o_app_wdf_end       = (r_state == S_WR_BEAT1);
    assign o_app_wdf_data      = w_wdf_active ? i_ddr_wr_data : '0;
    assign o_app_wdf_mask      = w_wdf_active ? i_ddr_wr_be_n : '0;

endmodule
`default_nettype wire

// File: tb/tb_user_ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_ddr_arbiter
// Purpose  : Vector table, directed corner sequences and random traffic
//            against a transaction-level model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_ddr_arbiter;

    localparam int c_max = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_ddr_rd_req, i_ddr_wr_req, i_app_rdy, i_app_wdf_rdy;
    logic         i_app_rd_data_valid, i_app_rd_data_end;
    logic [31:0]  i_ddr_rd_addr, i_ddr_wr_addr, i_ddr_wr_be_n;
    logic [255:0] i_ddr_wr_data, i_app_rd_data;
    logic         o_ddr_rd_ack, o_ddr_rd_data_valid, o_ddr_wr_ack;
    logic [255:0] o_ddr_rd_data, o_app_wdf_data;
    logic         o_app_en, o_app_wdf_wren, o_app_wdf_end;
    logic [2:0]   o_app_cmd;
    logic [31:0]  o_app_addr, o_app_wdf_mask;

    int total = 0;
    int bad   = 0;

    user_ddr_arbiter #(.ADDR_W(32), .MAX_RD_OUT(c_max)) dut (
        .i_ddr_clk(clk), .i_rst_n(rst_n),
        .i_ddr_rd_req(i_ddr_rd_req), .o_ddr_rd_ack(o_ddr_rd_ack), .i_ddr_rd_addr(i_ddr_rd_addr),
        .o_ddr_rd_data_valid(o_ddr_rd_data_valid), .o_ddr_rd_data(o_ddr_rd_data),
        .i_ddr_wr_req(i_ddr_wr_req), .o_ddr_wr_ack(o_ddr_wr_ack), .i_ddr_wr_addr(i_ddr_wr_addr),
        .i_ddr_wr_data(i_ddr_wr_data), .i_ddr_wr_be_n(i_ddr_wr_be_n),
        .o_app_en(o_app_en), .o_app_cmd(o_app_cmd), .o_app_addr(o_app_addr), .i_app_rdy(i_app_rdy),
        .o_app_wdf_wren(o_app_wdf_wren), .o_app_wdf_end(o_app_wdf_end),
        .o_app_wdf_data(o_app_wdf_data), .o_app_wdf_mask(o_app_wdf_mask), .i_app_wdf_rdy(i_app_wdf_rdy),
        .i_app_rd_data(i_app_rd_data), .i_app_rd_data_valid(i_app_rd_data_valid),
        .i_app_rd_data_end(i_app_rd_data_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        rd_req, wr_req, app_rdy, wdf_rdy, dv, dend;
        logic [31:0] be_n;
        logic        en;
        logic [2:0]  cmd;
        logic        wren, wend, rd_ack, wr_ack, rd_dv;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_inputs();
        i_ddr_rd_req = 0; i_ddr_wr_req = 0; i_app_rdy = 0; i_app_wdf_rdy = 0;
        i_app_rd_data_valid = 0; i_app_rd_data_end = 0;
        i_ddr_rd_addr = 0; i_ddr_wr_addr = 0; i_ddr_wr_be_n = 0;
        i_ddr_wr_data = '0; i_app_rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_app_en"}, o_app_en, 0);
        chk({tag, "_app_cmd"}, o_app_cmd, 0);
        chk({tag, "_app_addr"}, o_app_addr, 0);
        chk({tag, "_wren"}, o_app_wdf_wren, 0);
        chk({tag, "_wdf_end"}, o_app_wdf_end, 0);
        chk({tag, "_wdf_data"}, o_app_wdf_data, 0);
        chk({tag, "_wdf_mask"}, o_app_wdf_mask, 0);
        chk({tag, "_rd_ack"}, o_ddr_rd_ack, 0);
        chk({tag, "_wr_ack"}, o_ddr_wr_ack, 0);
        chk({tag, "_rd_dv"}, o_ddr_rd_data_valid, 0);
        chk({tag, "_rd_data"}, o_ddr_rd_data, 0);
    endtask

    vec_t tbl [10];

    initial begin
        vec_t v;
        int   nrd, nwr, nwcmd, nacc, owed;
        logic [4:0] pat;
        int   cmds [$];

        // rd wr ardy wrdy dv end be_n | en cmd wren wend rdack wrack rddv
        tbl[0] = '{1, 0, 1, 0, 0, 0, 32'h0,        0, 3'd0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0, 0, 0, 32'h0,        1, 3'd1, 0, 0, 1, 0, 0};
        tbl[2] = '{0, 0, 1, 0, 1, 0, 32'h0,        0, 3'd0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1, 0, 1, 1, 32'h0,        0, 3'd0, 0, 0, 0, 0, 1};
        tbl[4] = '{0, 1, 1, 1, 0, 0, 32'h0,        0, 3'd0, 0, 0, 0, 0, 1};
        tbl[5] = '{0, 1, 1, 1, 0, 0, 32'h0,        0, 3'd0, 1, 0, 0, 1, 0};
        tbl[6] = '{0, 1, 1, 1, 0, 0, 32'hF000000F, 0, 3'd0, 1, 1, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 0, 32'h0,        1, 3'd0, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 1, 0, 0, 32'h0,        1, 3'd0, 0, 0, 0, 0, 0};
        tbl[9] = '{0, 0, 1, 1, 0, 0, 32'h0,        0, 3'd0, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk_all_zero("reset");
        do_reset();

        // ---------------- vector table: one read, one write ----------------
        for (int r = 0; r < 10; r++) begin
            v = tbl[r];
            @(posedge clk); #1;
            i_ddr_rd_req = v.rd_req; i_ddr_wr_req = v.wr_req;
            i_app_rdy = v.app_rdy; i_app_wdf_rdy = v.wdf_rdy;
            i_app_rd_data_valid = v.dv; i_app_rd_data_end = v.dend;
            i_ddr_wr_be_n = v.be_n;
            i_ddr_rd_addr = 32'h40; i_ddr_wr_addr = 32'h80;
            i_ddr_wr_data = {8{32'hA000_0000 | 32'(r)}};
            i_app_rd_data = {8{32'h5000_0000 | 32'(r)}};
            @(negedge clk);
            chk("tbl_app_en", o_app_en, v.en);
            chk("tbl_app_cmd", o_app_cmd, v.cmd);
            chk("tbl_wren", o_app_wdf_wren, v.wren);
            chk("tbl_wdf_end", o_app_wdf_end, v.wend);
            chk("tbl_rd_ack", o_ddr_rd_ack, v.rd_ack);
            chk("tbl_wr_ack", o_ddr_wr_ack, v.wr_ack);
            chk("tbl_rd_dv", o_ddr_rd_data_valid, v.rd_dv);
            if (v.en) chk("tbl_app_addr", o_app_addr, (v.cmd == 3'd1) ? 32'h40 : 32'h80);
            if (v.wren) begin
                chk("tbl_wdf_data", o_app_wdf_data, i_ddr_wr_data);
                chk("tbl_wdf_mask", o_app_wdf_mask, v.be_n);
            end
            if (v.rd_dv) chk("tbl_rd_data", o_ddr_rd_data, {8{32'h5000_0000 | 32'(r - 1)}});
        end

        // ---------------- backpressure on command and write data ----------------
        do_reset();
        @(posedge clk); #1;
        i_ddr_rd_req = 1; i_ddr_rd_addr = 32'h1234; i_app_rdy = 0;
        @(negedge clk);
        chk("bp_idle_en", o_app_en, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_rd_en", o_app_en, 1);
            chk("bp_rd_addr", o_app_addr, 32'h1234);
            chk("bp_rd_ack_held", o_ddr_rd_ack, 0);
        end
        @(posedge clk); #1;
        i_app_rdy = 1;
        @(negedge clk);
        chk("bp_rd_ack", o_ddr_rd_ack, 1);
        @(posedge clk); #1;
        i_ddr_rd_req = 0; i_app_rd_data_valid = 1; i_app_rd_data_end = 1;
        @(negedge clk);
        chk("bp_idle_after_rd", o_app_en, 0);
        @(posedge clk); #1;
        i_app_rd_data_valid = 0; i_app_rd_data_end = 0;
        i_ddr_wr_req = 1; i_ddr_wr_addr = 32'h5678; i_app_wdf_rdy = 0; i_app_rdy = 0;
        @(negedge clk);
        chk("bp_idle_wren", o_app_wdf_wren, 0);
        pat = 5'b10010;
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            i_app_wdf_rdy = pat[k];
            i_ddr_wr_data = rand256();
            i_ddr_wr_be_n = $urandom;
            @(negedge clk);
            chk("bp_wren", o_app_wdf_wren, 1);
            chk("bp_wdf_data", o_app_wdf_data, i_ddr_wr_data);
            chk("bp_wdf_mask", o_app_wdf_mask, i_ddr_wr_be_n);
            chk("bp_wdf_end", o_app_wdf_end, nacc == 1);
            chk("bp_wr_ack", o_ddr_wr_ack, pat[k]);
            if (pat[k]) nacc++;
        end
        @(posedge clk); #1;
        i_ddr_wr_req = 0;
        @(negedge clk);
        chk("bp_wcmd_en_wait", o_app_en, 1);
        chk("bp_wcmd_wren_off", o_app_wdf_wren, 0);
        @(posedge clk); #1;
        i_app_rdy = 1;
        @(negedge clk);
        chk("bp_wcmd_en", o_app_en, 1);
        chk("bp_wcmd_cmd", o_app_cmd, 0);
        chk("bp_wcmd_addr", o_app_addr, 32'h5678);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_wcmd_done", o_app_en, 0);

        // ---------------- outstanding-read limit ----------------
        do_reset();
        @(posedge clk); #1;
        i_ddr_rd_req = 1; i_ddr_rd_addr = 32'h100; i_app_rdy = 1; i_app_wdf_rdy = 1;
        nrd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nrd += int'(o_ddr_rd_ack);
            @(posedge clk); #1;
        end
        chk("lim_two_reads", nrd, c_max);
        i_ddr_wr_req = 1; i_ddr_wr_addr = 32'h180;
        nwr = 0; nwcmd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nrd   += int'(o_ddr_rd_ack);
            nwr   += int'(o_ddr_wr_ack);
            nwcmd += int'(o_app_en && i_app_rdy && o_app_cmd == 3'd0);
            @(posedge clk); #1;
            if (nwr >= 2) i_ddr_wr_req = 0;
        end
        chk("lim_reads_stalled", nrd, c_max);
        chk("lim_write_beats", nwr, 2);
        chk("lim_write_cmd", nwcmd, 1);
        i_app_rd_data_valid = 1; i_app_rd_data_end = 1;
        @(posedge clk); #1;
        i_app_rd_data_valid = 0; i_app_rd_data_end = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nrd += int'(o_ddr_rd_ack);
            @(posedge clk); #1;
        end
        chk("lim_third_read", nrd, c_max + 1);

        // ---------------- async reset in the second write beat ----------------
        i_ddr_rd_req = 0; i_ddr_wr_req = 1; i_ddr_wr_addr = 32'h200;
        i_ddr_wr_data = rand256(); i_ddr_wr_be_n = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("ar_idle", o_app_wdf_wren, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_beat0", o_app_wdf_end, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_beat1_wren", o_app_wdf_wren, 1);
        chk("ar_beat1_end", o_app_wdf_end, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_ddr_rd_req = 1; i_ddr_rd_addr = 32'h300; i_app_rdy = 1;
        @(negedge clk);
        chk("ar_idle_after", o_app_en, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_rd_latency_en", o_app_en, 1);
        chk("ar_rd_addr", o_app_addr, 32'h300);
        nrd = int'(o_ddr_rd_ack);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            nrd += int'(o_ddr_rd_ack);
        end
        chk("ar_rd_out_cleared", nrd, c_max);

        // ---------------- alternation with both requests held ----------------
        do_reset();
        @(posedge clk); #1;
        i_ddr_rd_req = 1; i_ddr_wr_req = 1; i_ddr_rd_addr = 32'h10; i_ddr_wr_addr = 32'h20;
        i_app_rdy = 1; i_app_wdf_rdy = 1;
        owed = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_app_en && i_app_rdy) cmds.push_back(int'(o_app_cmd));
            if (o_ddr_rd_ack) owed++;
            @(posedge clk); #1;
            i_app_rd_data_valid = (owed > 0);
            i_app_rd_data_end   = (owed > 0);
            if (owed > 0) owed--;
        end
        chk("alt_cmd_count", cmds.size() >= 6, 1);
        for (int i = 0; i < 6; i++)
            if (i < cmds.size()) chk("alt_order", cmds[i], (i % 2 == 0) ? 1 : 0);

        // ---------------- random traffic vs. transaction model ----------------
        do_reset();
        begin
            bit   rd_pend, wr_pend, last_cmd_rd, prev_dv, rd_acc, wr_acc;
            int   cyc, wr_start, last_rd_cyc, wr_beats, model_out, burst_owed, beat_idx;
            int   rd_wait, wr_wait, max_rd_wait, max_wr_wait;
            logic [255:0] prev_data;
            logic [31:0]  exp_wcmd [$];
            rd_pend = 0; wr_pend = 0; last_cmd_rd = 0; prev_dv = 0; prev_data = '0;
            cyc = 0; wr_start = 0; last_rd_cyc = 0; wr_beats = 0;
            model_out = 0; burst_owed = 0; beat_idx = 0;
            rd_wait = 0; wr_wait = 0; max_rd_wait = 0; max_wr_wait = 0;
            for (int n = 0; n < 3000; n++) begin
                @(posedge clk); #1;
                cyc++;
                if (!rd_pend && $urandom_range(0, 3) == 0) begin
                    rd_pend = 1; i_ddr_rd_addr = $urandom; rd_wait = 0;
                end
                if (!wr_pend && $urandom_range(0, 3) == 0) begin
                    wr_pend = 1; wr_beats = 0; i_ddr_wr_addr = $urandom; wr_start = cyc; wr_wait = 0;
                end
                if (rd_pend) rd_wait++;
                if (wr_pend) wr_wait++;
                if (rd_wait > max_rd_wait) max_rd_wait = rd_wait;
                if (wr_wait > max_wr_wait) max_wr_wait = wr_wait;
                i_ddr_rd_req  = rd_pend;
                i_ddr_wr_req  = wr_pend;
                i_ddr_wr_data = rand256();
                i_ddr_wr_be_n = $urandom;
                i_app_rdy     = ($urandom_range(0, 3) != 0);
                i_app_wdf_rdy = ($urandom_range(0, 3) != 0);
                i_app_rd_data = rand256();
                i_app_rd_data_valid = (burst_owed > 0) && ($urandom_range(0, 1) == 1);
                i_app_rd_data_end   = i_app_rd_data_valid ? (beat_idx == 1) : 1'($urandom_range(0, 1));

                @(negedge clk);
                chk("rnd_rd_dv", o_ddr_rd_data_valid, prev_dv);
                if (prev_dv) chk("rnd_rd_data", o_ddr_rd_data, prev_data);
                prev_dv   = i_app_rd_data_valid;
                prev_data = i_app_rd_data;

                rd_acc = o_app_en && i_app_rdy && (o_app_cmd == 3'd1);
                chk("rnd_rd_ack", o_ddr_rd_ack, rd_acc);
                if (rd_acc) begin
                    chk("rnd_rd_req_pending", rd_pend, 1);
                    chk("rnd_rd_addr", o_app_addr, i_ddr_rd_addr);
                    chk("rnd_rd_limit", model_out < c_max, 1);
                    chk("rnd_rd_over_waiting_wr", last_cmd_rd && wr_pend && (wr_start <= last_rd_cyc), 0);
                    last_cmd_rd = 1; last_rd_cyc = cyc;
                    rd_pend = 0;
                    model_out++; burst_owed++;
                end

                wr_acc = o_app_wdf_wren && i_app_wdf_rdy;
                chk("rnd_wr_ack", o_ddr_wr_ack, wr_acc);
                if (o_app_wdf_wren) begin
                    chk("rnd_wdf_data", o_app_wdf_data, i_ddr_wr_data);
                    chk("rnd_wdf_mask", o_app_wdf_mask, i_ddr_wr_be_n);
                end
                if (wr_acc) begin
                    chk("rnd_wr_req_pending", wr_pend, 1);
                    chk("rnd_wdf_end", o_app_wdf_end, wr_beats == 1);
                    wr_beats++;
                    if (wr_beats == 2) begin
                        exp_wcmd.push_back(i_ddr_wr_addr);
                        wr_pend = 0;
                    end
                end
                if (o_app_en && i_app_rdy && o_app_cmd == 3'd0) begin
                    chk("rnd_wcmd_expected", exp_wcmd.size(), 1);
                    if (exp_wcmd.size() > 0) chk("rnd_wcmd_addr", o_app_addr, exp_wcmd.pop_front());
                    last_cmd_rd = 0;
                end

                if (i_app_rd_data_valid) begin
                    if (beat_idx == 1) begin
                        beat_idx = 0; burst_owed--; model_out--;
                    end else begin
                        beat_idx = 1;
                    end
                end
            end
            chk("rnd_rd_max_wait_ok", max_rd_wait <= 400, 1);
            chk("rnd_wr_max_wait_ok", max_wr_wait <= 400, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
